// File: rtl/ctrl_sequencer.sv
// ============================================================================
// ctrl_sequencer
// ----------------------------------------------------------------------------
// Control unit for the RISC microcontroller. It owns the
// LOAD/FETCH/DECODE/EXECUTE state machine and drives the enable/select set
// that the datapath expects. It also adds:
//   - a data-memory wait-state handshake for type-M instructions,
//   - a stall timeout that halts the core with a sticky fault,
//   - a software HALT instruction (OP=0000 with an all-ones low field).
//
// Optional feature:
//   CTRL_IRQ_EN  when defined, a level interrupt request is taken after the
//                final EXECUTE cycle of an instruction. The core then spends
//                one cycle in the IRQ state, loading the PC from the vector.
//                When undefined, irq is ignored and vec_sel/irq_ack stay 0.
//
// Parameters:
//   IR_W       instruction width (must be >= 8 + MODE_W)
//   MODE_W     ALU mode width
//   STALL_MAX  consecutive data-memory wait cycles allowed (1..255)
//
// Ports:
//   clk         system clock, rising-edge
//   rst         synchronous active-high reset
//   load_done   program load complete (only looked at in LOAD)
//   IR          instruction register contents
//   SR          status flags {O,S,C,Z}, indexed by the jump condition
//   dmem_ready  data memory completed its access this cycle
//   irq         interrupt request, level (only with CTRL_IRQ_EN)
//   stage       current state encoding
//   PC_E .. MUX2_Sel, ALU_Mode   datapath enables and selects
//   vec_sel     PC source is the interrupt vector
//   irq_ack     interrupt taken
//   halted      core is in HALT
//   fault       HALT was caused by a stall timeout (sticky until rst)
// ============================================================================
module ctrl_sequencer #(
    parameter int IR_W      = 12,
    parameter int MODE_W    = 4,
    parameter int STALL_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_done,
    input  logic [IR_W-1:0]   IR,
    input  logic [3:0]        SR,
    input  logic              dmem_ready,
    input  logic              irq,
    output logic [2:0]        stage,
    output logic              PC_E,
    output logic              Acc_E,
    output logic              SR_E,
    output logic              IR_E,
    output logic              DR_E,
    output logic              PMem_E,
    output logic              PMem_LE,
    output logic              DMem_E,
    output logic              DMem_WE,
    output logic              ALU_E,
    output logic              MUX1_Sel,
    output logic              MUX2_Sel,
    output logic [MODE_W-1:0] ALU_Mode,
    output logic              vec_sel,
    output logic              irq_ack,
    output logic              halted,
    output logic              fault
);

    localparam int LO_W = IR_W - 4;

    // The stall counter value seen during the last permitted wait cycle.
    // Waiting once more from this value would reach STALL_MAX.
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4,
        ST_IRQ     = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    state_t          out_state;
    logic [7:0]      stall_cnt;
    logic            fault_q;

    logic [3:0]      op;
    logic [LO_W-1:0] lo;
    logic            is_type_m;
    logic            is_halt_instr;
    logic            mem_wait;
    logic            exec_done;
    logic            stall_expire;
    logic            take_irq;

    assign op = IR[IR_W-1 -: 4];
    assign lo = IR[LO_W-1:0];

    // Instruction classification used by both the next-state logic and the
    // output decode. A type-M instruction is the only kind that waits on the
    // data memory; everything else completes in a single EXECUTE cycle. The
    // stall timeout fires on the last allowed wait cycle when the memory is
    // still not ready, so a late dmem_ready on that same cycle still wins.
    always_comb begin
        is_type_m     = (op[3:1] == 3'b001);
        is_halt_instr = (op == 4'b0000) && (&lo);
        mem_wait      = (state == ST_EXECUTE) && is_type_m && !dmem_ready;
        exec_done     = (state == ST_EXECUTE) && !mem_wait;
        stall_expire  = mem_wait && (stall_cnt >= STALL_LAST);
    end

`ifdef CTRL_IRQ_EN
    // Interrupts are only considered once an instruction has completed.
    // A HALT instruction takes priority in the next-state logic, so an
    // interrupt can never be taken in the same cycle as HALT.
    always_comb begin
        take_irq = exec_done && irq;
    end
`else
    // Without interrupt support the request line is deliberately unused.
    logic unused_irq;

    always_comb begin
        take_irq   = 1'b0;
        unused_irq = irq;
    end
`endif

    // Next-state logic. HALT is terminal; only rst brings the core back to
    // LOAD. In EXECUTE the timeout check comes first because it only applies
    // while still waiting, and completion then chooses between HALT, IRQ and
    // the next FETCH.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_LOAD: begin
                if (load_done) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (stall_expire) begin
                    state_next = ST_HALT;
                end else if (exec_done) begin
                    if (is_halt_instr) begin
                        state_next = ST_HALT;
                    end else if (take_irq) begin
                        state_next = ST_IRQ;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            ST_IRQ: begin
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // State register, stall counter and sticky fault flag. The counter is
    // cleared while DECODE hands over to EXECUTE, so every instruction
    // starts with a fresh count. It advances once per wait cycle and clears
    // again on completion. The fault flag is only cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            stall_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                stall_cnt <= '0;
            end else if (state == ST_EXECUTE) begin
                if (mem_wait) begin
                    stall_cnt <= stall_cnt + 8'd1;
                end else begin
                    stall_cnt <= '0;
                end
            end
            if (stall_expire) begin
                fault_q <= 1'b1;
            end
        end
    end

    // While rst is high the outputs decode as LOAD, whatever the state
    // register still holds. That way an instruction interrupted by reset
    // issues no further EXECUTE enables.
    always_comb begin
        out_state = rst ? ST_LOAD : state;
    end

    // Output decode. Everything defaults to 0 and each state turns on only
    // what it needs. In a type-M wait cycle the PC, accumulator and status
    // enables are held off so nothing commits. The memory strobes, ALU
    // enable, mode and mux selects stay stable for the memory.
    always_comb begin
        PC_E     = 1'b0;
        Acc_E    = 1'b0;
        SR_E     = 1'b0;
        IR_E     = 1'b0;
        DR_E     = 1'b0;
        PMem_E   = 1'b0;
        PMem_LE  = 1'b0;
        DMem_E   = 1'b0;
        DMem_WE  = 1'b0;
        ALU_E    = 1'b0;
        MUX1_Sel = 1'b0;
        MUX2_Sel = 1'b0;
        ALU_Mode = '0;
        unique case (out_state)
            ST_LOAD: begin
                PMem_LE = 1'b1;
                PMem_E  = 1'b1;
            end
            ST_FETCH: begin
                IR_E   = 1'b1;
                PMem_E = 1'b1;
            end
            ST_DECODE: begin
                if (is_type_m) begin
                    DR_E   = 1'b1;
                    DMem_E = 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (op[3]) begin
                    PC_E     = 1'b1;
                    Acc_E    = 1'b1;
                    SR_E     = 1'b1;
                    ALU_E    = 1'b1;
                    MUX1_Sel = 1'b1;
                    ALU_Mode = MODE_W'(op[2:0]);
                end else if (op[2]) begin
                    PC_E     = 1'b1;
                    MUX1_Sel = SR[op[1:0]];
                end else if (op[1]) begin
                    PC_E     = !mem_wait;
                    Acc_E    = op[0] && !mem_wait;
                    SR_E     = !mem_wait;
                    DMem_E   = !op[0];
                    DMem_WE  = !op[0];
                    ALU_E    = 1'b1;
                    MUX1_Sel = 1'b1;
                    MUX2_Sel = 1'b1;
                    ALU_Mode = lo[LO_W-1 -: MODE_W];
                end else if (op[0]) begin
                    PC_E     = 1'b1;
                    MUX1_Sel = 1'b0;
                end else if (!is_halt_instr) begin
                    PC_E     = 1'b1;
                    MUX1_Sel = 1'b1;
                end
            end
            ST_IRQ: begin
                PC_E = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Status outputs. stage mirrors the decoded state, so it reads 0 during
    // reset. fault is masked during reset even though the register only
    // clears on the edge.
    always_comb begin
        stage  = out_state;
        halted = (out_state == ST_HALT);
        fault  = fault_q && !rst;
    end

`ifdef CTRL_IRQ_EN
    // The IRQ state both acknowledges the request and steers the PC mux to
    // the vector for its single cycle.
    always_comb begin
        vec_sel = (out_state == ST_IRQ);
        irq_ack = (out_state == ST_IRQ);
    end
`else
    // Interrupts are not built in, so these outputs are tied off.
    always_comb begin
        vec_sel = 1'b0;
        irq_ack = 1'b0;
    end
`endif

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised control unit for the RISC microcontroller. It owns the load/fetch/decode/execute state machine internally instead of taking the stage from outside. It adds a data-memory wait-state handshake, a stall timeout with fault halt, and a software HALT. It sits between the program/data memories and the datapath, driving the same enable/select set as the datapath already expects.

## Interface
- IR_W, 12: instruction width; must be ≥ 8 + MODE_W.
- MODE_W, 4: ALU mode width.
- STALL_MAX, 15: maximum consecutive data-memory wait cycles before fault; 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_done  in  1  program load complete.
- IR  in  IR_W  instruction register contents.
- SR  in  4  status flags {O,S,C,Z} indexed by jump condition.
- dmem_ready  in  1  data memory completed the access this cycle.
- irq  in  1  interrupt request (level); used only with CTRL_IRQ_EN.
- stage  out  3  current state encoding.
- PC_E, Acc_E, SR_E, IR_E, DR_E, PMem_E, PMem_LE, DMem_E, DMem_WE, ALU_E, MUX1_Sel, MUX2_Sel  out  1 each  datapath enables/selects.
- ALU_Mode  out  MODE_W  ALU operation.
- vec_sel  out  1  PC source is the interrupt vector.
- irq_ack  out  1  interrupt taken.
- halted  out  1  core halted.
- fault  out  1  halt caused by stall timeout.

## Operation
- Opcode field: OP = IR[IR_W-1:IR_W-4]. Operand low field: LO = IR[IR_W-5:0].
- States: LOAD=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4, IRQ=5.
- Transitions:
  - LOAD→FETCH when load_done=1.
  - FETCH→DECODE.
  - DECODE→EXECUTE.
  - EXECUTE→FETCH on completion. Exceptions: →IRQ if irq=1 (macro builds only); →HALT on a HALT instruction or on fault.
  - IRQ→FETCH.
  - HALT holds until rst.
- Outputs are combinational from state, IR and SR. Any output not listed for a state is 0.
- LOAD: PMem_LE=1, PMem_E=1.
- FETCH: IR_E=1, PMem_E=1.
- DECODE: DR_E=DMem_E=1 when OP[3:1]=001.
- EXECUTE, by OP:
  - OP[3]=1 (ALU type-I): PC_E, Acc_E, SR_E, ALU_E, MUX1_Sel = 1. ALU_Mode = zero-extended OP[2:0].
  - OP[3:2]=01 (conditional jump): PC_E=1. MUX1_Sel = SR[OP[1:0]].
  - OP[3:1]=001 (type-M): PC_E=1, Acc_E=OP[0], SR_E=1, DMem_E=DMem_WE=!OP[0], ALU_E=1, MUX1_Sel=MUX2_Sel=1. ALU_Mode = LO[LO width-1 -: MODE_W].
  - OP=0000: NOP with PC_E=1, MUX1_Sel=1. If LO is all ones, it is HALT instead: PC_E=0 and next state is HALT.
  - OP=0001: GOTO with PC_E=1, MUX1_Sel=0.
- Type-M wait states, when dmem_ready=0 in EXECUTE:
  - State holds.
  - PC_E, Acc_E and SR_E are forced to 0.
  - DMem_E, DMem_WE, ALU_E, ALU_Mode and the MUX selects stay asserted.
  - An 8-bit stall counter increments each wait cycle.
  - If the counter reaches STALL_MAX while dmem_ready is still 0, next state is HALT and fault is set.
- The stall counter clears on entry to EXECUTE and on completion.
- dmem_ready is ignored for all non-type-M instructions.
- halted=1 in HALT. fault is a sticky register, cleared only by rst.

## Timing
- Reset: while rst=1, all outputs decode as LOAD: PMem_LE=PMem_E=1, everything else 0, stage=0. The state register loads LOAD on the next edge. halted, fault, irq_ack and the stall counter are 0.
- Reset asserted mid-instruction or mid-stall aborts the instruction; no EXECUTE enables are issued on the following cycle.
- Instruction latency with no wait states is 3 cycles (FETCH, DECODE, EXECUTE); with N wait states it is 3+N.
- load_done high for one cycle in LOAD is sufficient. load_done is ignored in all other states.
- Timeout: with STALL_MAX=15, the 15th consecutive wait cycle is the last cycle in EXECUTE; HALT follows.
- dmem_ready=1 on the same cycle the count would expire: completion wins and no fault is raised.

## Configuration
- CTRL_IRQ_EN defined:
  - irq is sampled in the final EXECUTE cycle, after completion, including jumps.
  - If irq=1, next state is IRQ. IRQ lasts one cycle with PC_E=1, vec_sel=1, irq_ack=1.
  - irq is never taken from HALT, from a stalled EXECUTE, or in the same cycle as a HALT instruction.
- CTRL_IRQ_EN undefined: irq is ignored, the IRQ state is unreachable, and vec_sel and irq_ack are constant 0.

## Test plan
- Reset then load_done pulse at cycle 5 → stage 0 for cycles 0–5; then 1, 2, 3 repeating; PMem_LE=0 after cycle 5.
- IR=12'hA12 (ALU type-I, OP=1010) → in EXECUTE: ALU_Mode=4'h2, Acc_E=SR_E=PC_E=MUX1_Sel=1, MUX2_Sel=0.
- IR=12'h250 (type-M store), dmem_ready low for 3 cycles → EXECUTE lasts 4 cycles. DMem_WE=1 throughout; PC_E=1 only in the last cycle; ALU_Mode=4'h5.
- Same store with dmem_ready held 0, STALL_MAX=15 → HALT after 15 wait cycles, fault=1, halted=1. Only rst recovers (stage=0, fault=0).
- IR=12'h0FF → HALT entered, PC_E never asserted. IR=12'h0FE → NOP then FETCH.
- With CTRL_IRQ_EN, irq=1 during a NOP execute → one IRQ cycle with vec_sel=irq_ack=PC_E=1, then FETCH. irq=1 during a stall → not taken until completion.
